writeback_stage: RTL and testbench

Memory/write-back stage controller that produces the 20-bit MEM/WB buffer consumed by the decoding stage's register-file write port. The buffer carries write-enable, destination address and write data. It accepts one retiring instruction per cycle from the memory stage. For loads it waits on a multi-cycle data-memory response, holding the pipeline with `stall`. A timeout guard and a retired-instruction counter are included, plus an optional same-cycle write bypass toward the decoding stage.

---
 rtl/writeback_stage_pkg.sv | 24 ++
 rtl/wb_bypass_cmp.sv | 19 +
 rtl/writeback_stage.sv | 186 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the memory/write-back stage.
// No logic of its own; holds defaults, MEM/WB field positions and the FSM state type.
// Imported by writeback_stage, wb_bypass_cmp and the bench.
package writeback_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    // MEM/WB buffer layout at the default widths: {write_back, write_addr, write_data}
    localparam int WB_BIT  = 19;
    localparam int ADDR_HI = 18;
    localparam int ADDR_LO = 16;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    // Width of the load-timeout counter: must hold MEM_TIMEOUT-1.
    function automatic int tmo_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/wb_bypass_cmp.sv
// Compares one decoding-stage read address against the pending MEM/WB write.
// Purely combinational, zero latency from the registered buffer.
// No backpressure; the hit is qualified only by the buffer's write-back bit.
module wb_bypass_cmp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              i_wb_vld,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_dat,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_dat
);

    assign o_hit = i_wb_vld && (i_wb_addr == i_rd_addr);
    assign o_dat = i_wb_dat;

endmodule

// File: rtl/writeback_stage.sv
// Memory/write-back controller producing the MEM/WB register-file write buffer.
// ALU results: 1 cycle; loads: response arrival + 1 edge; abort after MEM_TIMEOUT wait cycles.
// Combinational stall holds upstream while a load waits; optional bypass under WB_BYPASS_EN.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_wb,
    input  logic                     in_mem_to_reg,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_alu_result,
    input  logic                     mem_rd_valid,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     stall,
    output logic [DATA_W+ADDR_W:0]   mem_wb_buffer,
    output logic [15:0]              retire_cnt,
    output logic                     mem_err
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]        src_addr,
    input  logic [ADDR_W-1:0]        dst_addr,
    output logic                     byp_src_hit,
    output logic                     byp_dst_hit,
    output logic [DATA_W-1:0]        byp_data
`endif
);

    localparam int TMO_W = tmo_width(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_wb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [15:0]       r_retire_cnt;
    logic              r_mem_err;

    logic              w_stall;
    logic              w_wb_nxt;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_retire;
    logic              w_abort;
    logic              w_issue;
    logic              w_tmo_inc;

    // Next-state and per-cycle actions; addr/data hold unless a write is produced.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_wb_nxt    = 1'b0;
        w_wr_addr   = r_addr;
        w_wr_data   = r_data;
        w_retire    = 1'b0;
        w_abort     = 1'b0;
        w_issue     = 1'b0;
        w_tmo_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!in_wb) begin
                        w_retire = 1'b1;
                    end else if (!in_mem_to_reg) begin
                        w_wb_nxt  = 1'b1;
                        w_wr_addr = in_addr;
                        w_wr_data = in_alu_result;
                        w_retire  = 1'b1;
                    end else if (mem_rd_valid) begin
                        // Load whose data is already back completes without stalling.
                        w_wb_nxt  = 1'b1;
                        w_wr_addr = in_addr;
                        w_wr_data = mem_rd_data;
                        w_retire  = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_issue     = 1'b1;
                        w_state_nxt = ST_WAIT_MEM;
                    end
                end
            end
            ST_WAIT_MEM: begin
                // A response always wins over the timeout in the same cycle.
                if (mem_rd_valid) begin
                    w_wb_nxt    = 1'b1;
                    w_wr_addr   = r_pend_addr;
                    w_wr_data   = mem_rd_data;
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_tmo_cnt == TMO_LAST) begin
                        w_abort     = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_tmo_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending-load bookkeeping, MEM/WB buffer, retire counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_addr  <= '0;
            r_tmo_cnt    <= '0;
            r_wb         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_retire_cnt <= '0;
            r_mem_err    <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pend_addr <= in_addr;
                r_tmo_cnt   <= '0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            r_wb   <= w_wb_nxt;
            r_addr <= w_wr_addr;
            r_data <= w_wr_data;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end
            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign stall         = w_stall;
    assign mem_wb_buffer = {r_wb, r_addr, r_data};
    assign retire_cnt    = r_retire_cnt;
    assign mem_err       = r_mem_err;

`ifdef WB_BYPASS_EN
    logic              w_src_hit;
    logic              w_dst_hit;
    logic [DATA_W-1:0] w_src_dat;
    logic [DATA_W-1:0] w_dst_dat;

    wb_bypass_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_src (
        .i_wb_vld  (r_wb),
        .i_wb_addr (r_addr),
        .i_wb_dat  (r_data),
        .i_rd_addr (src_addr),
        .o_hit     (w_src_hit),
        .o_dat     (w_src_dat)
    );

    wb_bypass_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_dst (
        .i_wb_vld  (r_wb),
        .i_wb_addr (r_addr),
        .i_wb_dat  (r_data),
        .i_rd_addr (dst_addr),
        .o_hit     (w_dst_hit),
        .o_dat     (w_dst_dat)
    );

    // Both comparators carry the same buffer data; pick whichever side hit.
    assign byp_src_hit = w_src_hit;
    assign byp_dst_hit = w_dst_hit;
    assign byp_data    = w_src_hit ? w_src_dat : w_dst_dat;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios then random traffic vs. a behavioural model.
// Inputs driven 1 time unit after the rising edge; stall sampled on the falling edge.
// Registered outputs compared 1 time unit after each rising edge.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_wb;
    logic          in_mem_to_reg;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_alu_result;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic          stall;
    logic [DW+AW:0] mem_wb_buffer;
    logic [15:0]   retire_cnt;
    logic          mem_err;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          byp_src_hit;
    logic          byp_dst_hit;
    logic [DW-1:0] byp_data;
`endif

    writeback_stage #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_wb         (in_wb),
        .in_mem_to_reg (in_mem_to_reg),
        .in_addr       (in_addr),
        .in_alu_result (in_alu_result),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .stall         (stall),
        .mem_wb_buffer (mem_wb_buffer),
        .retire_cnt    (retire_cnt),
        .mem_err       (mem_err)
`ifdef WB_BYPASS_EN
        ,
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .byp_src_hit   (byp_src_hit),
        .byp_dst_hit   (byp_dst_hit),
        .byp_data      (byp_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one outstanding load at most, counted in waited cycles.
    bit            m_pend;
    int            m_wait;
    logic [AW-1:0] m_paddr;
    logic          exp_wb;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [15:0]   exp_cnt;
    logic          exp_err;
    logic          exp_stall;
    logic          last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend   = 1'b0;
        m_wait   = 0;
        m_paddr  = '0;
        exp_wb   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_cnt  = '0;
        exp_err  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic wb, input logic m2r,
                              input logic [AW-1:0] a, input logic [DW-1:0] alu,
                              input logic rv, input logic [DW-1:0] rd);
        exp_wb = 1'b0;
        if (m_pend) begin
            if (rv) begin
                exp_wb   = 1'b1;
                exp_addr = m_paddr;
                exp_data = rd;
                exp_cnt  = exp_cnt + 16'd1;
                m_pend   = 1'b0;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == TMO) begin
                    exp_err = 1'b1;
                    exp_cnt = exp_cnt + 16'd1;
                    m_pend  = 1'b0;
                end
            end
        end else if (v) begin
            if (!wb) begin
                exp_cnt = exp_cnt + 16'd1;
            end else if (!m2r || rv) begin
                exp_wb   = 1'b1;
                exp_addr = a;
                exp_data = m2r ? rd : alu;
                exp_cnt  = exp_cnt + 16'd1;
            end else begin
                m_pend  = 1'b1;
                m_wait  = 0;
                m_paddr = a;
            end
        end
    endtask

    task automatic check_outputs();
        chk("buffer", 32'(mem_wb_buffer), 32'({exp_wb, exp_addr, exp_data}));
        chk("retire_cnt", 32'(retire_cnt), 32'(exp_cnt));
        chk("mem_err", 32'(mem_err), 32'(exp_err));
`ifdef WB_BYPASS_EN
        chk("byp_src_hit", 32'(byp_src_hit), 32'(exp_wb && (exp_addr == src_addr)));
        chk("byp_dst_hit", 32'(byp_dst_hit), 32'(exp_wb && (exp_addr == dst_addr)));
        chk("byp_data", 32'(byp_data), 32'(exp_data));
`endif
    endtask

    task automatic step(input logic v, input logic wb, input logic m2r,
                        input logic [AW-1:0] a, input logic [DW-1:0] alu,
                        input logic rv, input logic [DW-1:0] rd);
        in_valid      = v;
        in_wb         = wb;
        in_mem_to_reg = m2r;
        in_addr       = a;
        in_alu_result = alu;
        mem_rd_valid  = rv;
        mem_rd_data   = rd;
        @(negedge clk);
        exp_stall  = m_pend ? !rv : (v && wb && m2r && !rv);
        last_stall = stall;
        chk("stall", 32'(stall), 32'(exp_stall));
        model_edge(v, wb, m2r, a, alu, rv, rd);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_wb         = 1'b0;
        in_mem_to_reg = 1'b0;
        in_addr       = '0;
        in_alu_result = '0;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs();
        #1;
        chk("reset_stall", 32'(stall), 32'(0));
    endtask

    initial begin
        int stall_cycles;
        bit wb_seen;
        logic v, wb, m2r, rv;

`ifdef WB_BYPASS_EN
        src_addr = '0;
        dst_addr = '0;
`endif
        // Reset and three idle cycles.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        chk("idle_buffer", 32'(mem_wb_buffer), 32'h0);
        chk("idle_cnt", 32'(retire_cnt), 32'd0);

        // ALU write r3 = 0x1234, then the write-back pulse must drop.
        step(1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 1'b0, 16'h0);
        chk("alu_buffer", 32'(mem_wb_buffer), 32'h0B1234);
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        chk("alu_pulse_drop", 32'(mem_wb_buffer[WB_BIT]), 32'd0);
        chk("alu_cnt", 32'(retire_cnt), 32'd1);

        // Load r5, response 5 cycles after issue; in_valid during the wait is ignored.
        stall_cycles = 0;
        step(1'b1, 1'b1, 1'b1, 3'd5, 16'h0, 1'b0, 16'h0);
        stall_cycles += int'(last_stall);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 3'(i), 16'($urandom), 1'b0, 16'h0);
            stall_cycles += int'(last_stall);
        end
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'hBEEF);
        stall_cycles += int'(last_stall);
        chk("load_stall_cycles", 32'(stall_cycles), 32'd5);
        chk("load_buffer", 32'(mem_wb_buffer), 32'h0DBEEF);
        chk("load_cnt", 32'(retire_cnt), 32'd2);

        // Load r6 with no response: abort after MEM_TIMEOUT waiting cycles.
        step(1'b1, 1'b1, 1'b1, 3'd6, 16'h0, 1'b0, 16'h0);
        chk("tmo_issue_stall", 32'(last_stall), 32'd1);
        stall_cycles = 0;
        wb_seen      = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
            stall_cycles += int'(last_stall);
            wb_seen |= mem_wb_buffer[WB_BIT];
        end
        chk("tmo_wait_stall_cycles", 32'(stall_cycles), 32'(TMO));
        chk("tmo_mem_err", 32'(mem_err), 32'd1);
        chk("tmo_no_write", 32'(wb_seen), 32'd0);
        chk("tmo_cnt", 32'(retire_cnt), 32'd3);
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        chk("tmo_back_idle", 32'(last_stall), 32'd0);

        // Load with same-cycle data, then back-to-back ALU writes r1, r2.
        step(1'b1, 1'b1, 1'b1, 3'd7, 16'h0, 1'b1, 16'hCAFE);
        chk("fast_load_stall", 32'(last_stall), 32'd0);
        chk("fast_load_buffer", 32'(mem_wb_buffer), 32'h0FCAFE);
        step(1'b1, 1'b1, 1'b0, 3'd1, 16'h1111, 1'b0, 16'h0);
        chk("b2b_r1", 32'(mem_wb_buffer), 32'h091111);
        step(1'b1, 1'b1, 1'b0, 3'd2, 16'h2222, 1'b0, 16'h0);
        chk("b2b_r2", 32'(mem_wb_buffer), 32'h0A2222);
        chk("b2b_cnt", 32'(retire_cnt), 32'd6);

        // Stray read data with no load pending is ignored; non-writing instr retires.
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h5555);
        step(1'b1, 1'b0, 1'b0, 3'd4, 16'h7777, 1'b0, 16'h0);
        chk("nowb_cnt", 32'(retire_cnt), 32'd7);
        chk("mem_err_sticky", 32'(mem_err), 32'd1);

        // Reset in the middle of a load wait: no write, no count, back to IDLE.
        step(1'b1, 1'b1, 1'b1, 3'd3, 16'h0, 1'b0, 16'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h9999);
        chk("rst_abort_cnt", 32'(retire_cnt), 32'd0);

`ifdef WB_BYPASS_EN
        src_addr = 3'd4;
        dst_addr = 3'd2;
        step(1'b1, 1'b1, 1'b0, 3'd4, 16'h00AA, 1'b0, 16'h0);
        chk("byp_src", 32'(byp_src_hit), 32'd1);
        chk("byp_dst", 32'(byp_dst_hit), 32'd0);
        chk("byp_val", 32'(byp_data), 32'h00AA);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(3) != 0);
            wb  = ($urandom_range(3) != 0);
            m2r = $urandom_range(1) == 1;
            rv  = ($urandom_range(2) == 0);
`ifdef WB_BYPASS_EN
            src_addr = 3'($urandom);
            dst_addr = 3'($urandom);
`endif
            step(v, wb, m2r, 3'($urandom), 16'($urandom), rv, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
